// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine for MULT/DIV instructions: one bit per cycle
// on a shared shift/add/subtract datapath, with sign fixup and a one-cycle done pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, FIXUP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic             sign_a;
    logic             sign_b;
    logic             is_div;
    logic [CNT_W-1:0] cnt;

    logic signed [WIDTH-1:0] op_a_s;
    logic signed [WIDTH-1:0] op_b_s;
    assign op_a_s = $signed(op_a);
    assign op_b_s = $signed(op_b);

    // |-2^(W-1)| wraps to the same bit pattern, which is exactly 2^(W-1) read unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate2_if(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    // Shared adder: multiply adds the multiplicand; divide adds ~divisor+1 and reads carry as "no borrow".
    logic [WIDTH:0]   alu_a;
    logic [WIDTH:0]   alu_b;
    logic             alu_cin;
    logic [WIDTH+1:0] alu_sum;
    logic [WIDTH:0]   mul_res;

    always_comb begin
        alu_a   = {1'b0, acc_hi};
        alu_b   = {1'b0, operand};
        alu_cin = 1'b0;
        if (state == DIV_RUN) begin
            alu_a   = {acc_hi, acc_lo[WIDTH-1]};
            alu_b   = ~{1'b0, operand};
            alu_cin = 1'b1;
        end
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{(WIDTH+1){1'b0}}, alu_cin};
        mul_res = acc_lo[0] ? alu_sum[WIDTH:0] : {1'b0, acc_hi};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    cnt  <= '0;
                    if (mult_start) begin
                        state   <= MUL_RUN;
                        busy    <= 1'b1;
                        is_div  <= 1'b0;
                        sign_a  <= op_a[WIDTH-1];
                        sign_b  <= op_b[WIDTH-1];
                        acc_hi  <= '0;
                        acc_lo  <= magnitude(op_b_s);
                        operand <= magnitude(op_a_s);
                    end else if (div_start) begin
                        busy   <= 1'b1;
                        is_div <= 1'b1;
                        sign_a <= op_a[WIDTH-1];
                        sign_b <= op_b[WIDTH-1];
                        if (op_b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            hi_out   <= op_a;
                            lo_out   <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            state   <= DIV_RUN;
                            acc_hi  <= '0;
                            acc_lo  <= magnitude(op_a_s);
                            operand <= magnitude(op_b_s);
                        end
                    end
                end
                MUL_RUN: begin
                    acc_hi <= mul_res[WIDTH:1];
                    acc_lo <= {mul_res[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
                end
                DIV_RUN: begin
                    if (alu_sum[WIDTH+1]) begin
                        acc_hi <= alu_sum[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= alu_a[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    if (is_div) begin
                        lo_out <= negate_if(acc_lo, sign_a ^ sign_b);
                        hi_out <= negate_if(acc_hi, sign_a);
                    end else begin
                        {hi_out, lo_out} <= negate2_if({acc_hi, acc_lo}, sign_a ^ sign_b);
                    end
                    div_zero <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
